// File: rtl/elevator_car_controller.sv
// elevator_car_controller
//   Car-side controller: latches call buttons, steps the car one floor at a
//   time on request from the direction calculator, holds the door open at
//   called floors and clears served calls.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   call_req[7:0]  in   call button pulses, one bit per floor
//   direction      in   1 = up, 0 = down (sampled in IDLE only)
//   should_move    in   move-one-floor request (sampled in IDLE only)
//   floors_called  out  registered pending-call vector
//   current_floor  out  registered car position 0..7
//   door_open      out  high while in DOOR
//   moving         out  high while in MOVING
module elevator_car_controller #(
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] call_req,
    input  logic       direction,
    input  logic       should_move,
    output logic [7:0] floors_called,
    output logic [2:0] current_floor,
    output logic       door_open,
    output logic       moving
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMoving = 2'd1,
        StDoor   = 2'd2
    } state_e;

    localparam logic [31:0] TravelLoad = 32'(TRAVEL_CYCLES - 1);
    localparam logic [31:0] DoorLoad   = 32'(DOOR_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic [2:0]  floor_q, floor_d;
    logic [7:0]  called_q, called_d;
    logic [7:0]  merged;
    logic [7:0]  clr;
    logic        move_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            floor_q  <= 3'd0;
            called_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            floor_q  <= floor_d;
            called_q <= called_d;
        end
    end

    assign merged     = called_q | call_req;
    assign move_legal = direction ? (floor_q != 3'd7) : (floor_q != 3'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        clr     = 8'h00;

        case (state_q)
            StIdle: begin
                // Door service wins over movement.
                if (called_q[floor_q]) begin
                    state_d = StDoor;
                    cnt_d   = DoorLoad;
                end else if (should_move && move_legal) begin
                    state_d = StMoving;
                    dir_d   = direction;
                    cnt_d   = TravelLoad;
                end
            end
            StMoving: begin
                if (cnt_q == 32'd0) begin
                    floor_d = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
                    // A press at the arriving floor on the arrival edge still opens the door.
                    if (merged[floor_d]) begin
                        state_d = StDoor;
                        cnt_d   = DoorLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StDoor: begin
                if (call_req[floor_q]) begin
                    cnt_d = DoorLoad;
                end else if (cnt_q == 32'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Clear against the post-edge floor so an arrival-edge press is dropped.
        if (state_d == StDoor || state_q == StDoor) begin
            clr = 8'h01 << floor_d;
        end
    end

    assign called_d = merged & ~clr;

    assign floors_called = called_q;
    assign current_floor = floor_q;
    assign door_open     = (state_q == StDoor);
    assign moving        = (state_q == StMoving);

endmodule
